// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcodes, FSM encoding and default width for the HI/LO multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU into HI/LO, with MTHI/MTLO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic             MT_HI,
  input  logic             MT_LO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic is_div, neg_res, neg_rem, sgn, sa, sb, ge;
  logic [WIDTH-1:0] acc, lo_sh, b_mag, a_abs, b_abs, rem_diff, quo_fix, rem_fix;
  logic [WIDTH:0] sum, rem_sh;
  logic [2*WIDTH-1:0] prod, prod_fix;
  assign sgn = (OP == OP_MULT) || (OP == OP_DIV);
  assign sa = sgn & SRC_A[WIDTH-1];
  assign sb = sgn & SRC_B[WIDTH-1];
  assign a_abs = sa ? -SRC_A : SRC_A;
  assign b_abs = sb ? -SRC_B : SRC_B;
  // multiply: {acc, lo_sh} is the product shifting right, multiplier bits consumed from lo_sh[0]
  assign sum = {1'b0, acc} + (lo_sh[0] ? {1'b0, b_mag} : '0);
  // divide: acc is the partial remainder, lo_sh shifts dividend out and quotient in
  assign rem_sh = {acc, lo_sh[WIDTH-1]};
  assign ge = rem_sh >= {1'b0, b_mag};
  assign rem_diff = rem_sh[WIDTH-1:0] - b_mag;
  assign prod = {acc, lo_sh};
  assign prod_fix = neg_res ? -prod : prod;
  // divide by zero leaves quotient all ones and remainder restores to SRC_A via dividend sign
  assign quo_fix = (neg_res && b_mag != '0) ? -lo_sh : lo_sh;
  assign rem_fix = neg_rem ? -acc : acc;
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE) ? (START ? RUN : IDLE) :
              (state == RUN) ? ((cnt == '0) ? FIX : RUN) : IDLE;
  end
  always_comb begin
    BUSY = state != IDLE;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc <= '0;
      lo_sh <= '0;
      b_mag <= '0;
      HI <= '0;
      LO <= '0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == IDLE) begin
        if (START) begin
          is_div <= OP[1];
          neg_res <= sa ^ sb;
          neg_rem <= sa;
          b_mag <= b_abs;
          acc <= '0;
          lo_sh <= a_abs;
          cnt <= CW'(WIDTH - 1);
        end else begin
          if (MT_HI) HI <= SRC_A;
          if (MT_LO) LO <= SRC_A;
        end
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
        if (is_div) begin
          acc <= ge ? rem_diff : rem_sh[WIDTH-1:0];
          lo_sh <= {lo_sh[WIDTH-2:0], ge};
        end else begin
          acc <= sum[WIDTH:1];
          lo_sh <= {sum[0], lo_sh[WIDTH-1:1]};
        end
      end else begin
        HI <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        LO <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
        DONE <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit with hand-computed HI/LO results
module tb_mult_div_unit;
  import mdu_pkg::*;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic START = 1'b0;
  logic MT_HI = 1'b0;
  logic MT_LO = 1'b0;
  logic [1:0] OP = 2'b00;
  logic [31:0] SRC_A = '0;
  logic [31:0] SRC_B = '0;
  logic BUSY, DONE;
  logic [31:0] HI, LO;
  int tests = 0;
  int fails = 0;
  always #5 CLOCK = ~CLOCK;
  mult_div_unit #(.WIDTH(32)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .OP(OP), .SRC_A(SRC_A), .SRC_B(SRC_B),
    .MT_HI(MT_HI), .MT_LO(MT_LO), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
  );
  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    OP = op;
    SRC_A = a;
    SRC_B = b;
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask
  task automatic check_op(input string tag, input int pre, input logic [31:0] hi, input logic [31:0] lo);
    int n;
    n = 0;
    while (BUSY && n < 40) begin
      n++;
      tick;
    end
    chk({tag, " busy_cycles"}, 32'(n + pre), 32'd33);
    chk({tag, " done"}, {31'd0, DONE}, 32'd1);
    chk({tag, " hi"}, HI, hi);
    chk({tag, " lo"}, LO, lo);
    tick;
    chk({tag, " done_drop"}, {31'd0, DONE}, 32'd0);
  endtask
  initial begin
    #12;
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    chk("reset busy", {31'd0, BUSY}, 32'd0);
    chk("reset done", {31'd0, DONE}, 32'd0);
    RESET = 1'b0;
    SRC_A = 32'h12345678;
    MT_HI = 1'b1;
    tick;
    MT_HI = 1'b0;
    chk("mthi hi", HI, 32'h12345678);
    chk("mthi lo", LO, 32'd0);
    SRC_A = 32'hA5A5A5A5;
    MT_HI = 1'b1;
    MT_LO = 1'b1;
    tick;
    MT_HI = 1'b0;
    MT_LO = 1'b0;
    chk("mtboth hi", HI, 32'hA5A5A5A5);
    chk("mtboth lo", LO, 32'hA5A5A5A5);
    launch(OP_MULT, 32'd7, 32'hFFFFFFFD);
    chk("mult busy_start", {31'd0, BUSY}, 32'd1);
    chk("mult hold_lo", LO, 32'hA5A5A5A5);
    check_op("mult 7*-3", 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("multu max", 0, 32'hFFFFFFFE, 32'h00000001);
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
    check_op("div -7/2", 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(OP_DIVU, 32'd100, 32'd0);
    check_op("divu 100/0", 0, 32'h00000064, 32'hFFFFFFFF);
    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    check_op("div ovf", 0, 32'h00000000, 32'h80000000);
    launch(OP_DIV, 32'hFFFFFFF9, 32'd0);
    check_op("div -7/0", 0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    launch(OP_DIV, 32'd100, 32'hFFFFFFF9);
    check_op("div 100/-7", 0, 32'h00000002, 32'hFFFFFFF2);
    launch(OP_MULT, 32'h80000000, 32'h80000000);
    check_op("mult min*min", 0, 32'h40000000, 32'h00000000);
    launch(OP_MULTU, 32'd3, 32'd5);
    tick;
    SRC_A = 32'hDEADBEEF;
    MT_LO = 1'b1;
    tick;
    MT_LO = 1'b0;
    chk("mtlo busy ignored", LO, 32'h00000000);
    check_op("multu 3*5", 2, 32'h00000000, 32'h0000000F);
    OP = OP_MULTU;
    SRC_A = 32'd6;
    SRC_B = 32'd7;
    START = 1'b1;
    MT_LO = 1'b1;
    tick;
    START = 1'b0;
    MT_LO = 1'b0;
    chk("start+mtlo lo held", LO, 32'h0000000F);
    check_op("multu 6*7", 0, 32'h00000000, 32'h0000002A);
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick;
    OP = OP_MULTU;
    SRC_A = 32'd2;
    SRC_B = 32'd3;
    START = 1'b1;
    tick;
    START = 1'b0;
    check_op("divu 100/7", 5, 32'd2, 32'd14);
    repeat (3) tick;
    chk("no second done", {31'd0, DONE}, 32'd0);
    chk("no second busy", {31'd0, BUSY}, 32'd0);
    chk("no second lo", LO, 32'd14);
    launch(OP_MULT, 32'd9, 32'd9);
    repeat (9) tick;
    #1 RESET = 1'b1;
    #1;
    chk("midreset hi", HI, 32'd0);
    chk("midreset lo", LO, 32'd0);
    chk("midreset busy", {31'd0, BUSY}, 32'd0);
    #1 RESET = 1'b0;
    tick;
    chk("postreset done", {31'd0, DONE}, 32'd0);
    launch(OP_MULT, 32'd7, 32'hFFFFFFFD);
    check_op("postreset mult", 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two read-data words (rs, rt) and executes MULT, MULTU, DIV and DIVU one bit per cycle, writing the results into architectural HI/LO registers. It also services MTHI/MTLO writes, and exposes BUSY so the hazard logic can stall MFHI/MFLO until the result is ready.

Parameters:
WIDTH, 32, operand width and number of iteration cycles

Ports:
CLOCK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  launch operation OP on SRC_A/SRC_B; sampled only in IDLE
OP  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
SRC_A  input  WIDTH  rs operand (register-file RD1); multiplicand/dividend; MTHI/MTLO data
SRC_B  input  WIDTH  rt operand (register-file RD2); multiplier/divisor
MT_HI  input  1  write SRC_A into HI
MT_LO  input  1  write SRC_A into LO
BUSY  output  1  operation in flight; HI/LO not yet valid
DONE  output  1  one-cycle pulse: HI/LO just updated by a completed operation
HI  output  WIDTH  HI register (product high word / remainder)
LO  output  WIDTH  LO register (product low word / quotient)

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE; HI=0, LO=0, BUSY=0, DONE=0; the in-flight operation is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, START=1 at edge 0:
  - Latch OP and operand magnitudes; for signed ops take two's-complement absolute values and record the result and remainder signs.
  - Counter set to WIDTH-1; go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge.
  - Counter decrements each edge; leave to FIX when counter=0. RUN lasts exactly WIDTH edges.
- FIX, one edge:
  - Signed multiply: negate the 2*WIDTH product if operand signs differ.
  - Signed divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - HI/LO are written on this edge, DONE=1 for the following cycle, then return to IDLE.
- Latency: START sampled at edge 0; HI/LO/DONE valid after edge WIDTH+1 (33 for WIDTH=32). BUSY=1 exactly for the cycles between edge 0 and edge WIDTH+1.
- DONE is 0 in all other cycles. HI/LO hold their previous value throughout RUN/FIX.
- START while BUSY: ignored, no queueing.
- MT_HI/MT_LO in IDLE: write SRC_A into HI/LO on the next edge. Both asserted writes both registers. Ignored while BUSY.
- START together with MT_HI/MT_LO in IDLE: START accepted, MT writes dropped.
- Divide by zero (DIV or DIVU): LO=all ones, HI=SRC_A unchanged, no sign fix; full latency still applies.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Results are modulo 2^WIDTH; no exceptions.
- All arithmetic is unsigned internally: product 2*WIDTH bits; divider partial remainder WIDTH+1 bits.

Decomposition:
- Shared package mdu_pkg:
  - OP code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state encoding (IDLE, RUN, FIX)
  - WIDTH default
- No sub-module required. An optional combinational helper mdu_negate (conditional two's-complement) may be instantiated for the absolute-value and FIX stages.

Test Plan:
- MULT SRC_A=7, SRC_B=0xFFFFFFFD -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB, DONE pulses one cycle, BUSY high for 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/7 running; second START (MULTU 2*3) at cycle 5 -> ignored; result LO=14, HI=2 at edge 33, no second DONE.
- Mid-operation reset at cycle 10 of a MULT -> HI=LO=0, BUSY=0 immediately. Next START completes normally with full latency.
- IDLE: MT_HI with SRC_A=0x12345678 -> HI=0x12345678 next cycle. MT_LO during BUSY -> LO unchanged. START+MT_LO together -> only the operation result appears.
